// File: rtl/lane_steer_pkg.sv
// Shared constants and helpers for the lane steering mux.
// Pure functions, no state; no flow control of its own.
// Width helpers assume LANES is a power of two.
package lane_steer_pkg;

  localparam int DEF_LANES   = 4;
  localparam int DEF_LANE_IW = $clog2(DEF_LANES);

  function automatic logic sel_match(input int v, input int lanes);
    return v < lanes;
  endfunction

  // lanes is a power of two, so the modulo is a mask
  function automatic int lane_of(input int k, input int v, input int lanes);
    return (v + k) & (lanes - 1);
  endfunction

endpackage

// File: rtl/lane_steer_prio_enc.sv
// NSEL-way priority encoder: field 0 wins, picks lane (v + k) mod LANES.
// Combinational, zero latency; no backpressure involvement.
// Reports miss with lane 0 when no field holds a value below LANES.
module lane_steer_prio_enc
  import lane_steer_pkg::*;
#(
  parameter int LANES = 4,
  parameter int NSEL  = 4,
  parameter int SEL_W = 4,
  parameter int LW    = $clog2(LANES)
) (
  input  logic [NSEL*SEL_W-1:0] sel_i,
  output logic [LW-1:0]         lane_o,
  output logic                  miss_o
);

  always_comb begin
    lane_o = '0;
    miss_o = 1'b1;
    // Walk from the lowest priority up so the lowest matching index overwrites last
    for (int k = NSEL - 1; k >= 0; k--) begin
      if (sel_match(int'(sel_i[k*SEL_W +: SEL_W]), LANES)) begin
        lane_o = LW'(lane_of(k, int'(sel_i[k*SEL_W +: SEL_W]), LANES));
        miss_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lane_steer_mux.sv
// Byte-lane steering mux: passes one selected lane, zeroes the rest (LANE_STEER_ALIGN_EN shifts it to lane 0).
// Latency 2 cycles (decode stage + mask stage), one word per cycle.
// Two-entry skid via the stage registers; in_ready drops once both stages hold words under out_ready=0.
module lane_steer_mux
  import lane_steer_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int NSEL   = 4,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in_data,
  input  logic [NSEL*SEL_W-1:0]     in_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic [$clog2(LANES)-1:0]  out_lane,
  output logic                      out_miss,
  input  logic                      count_clr,
  output logic [CNT_W-1:0]          hit_count
);

  localparam int LW = $clog2(LANES);
  localparam int DW = LANES * LANE_W;

  logic [LW-1:0]    enc_lane;
  logic             enc_miss;

  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    s1_data_q,  s1_data_d;
  logic [LW-1:0]    s1_lane_q,  s1_lane_d;
  logic             s1_miss_q,  s1_miss_d;

  logic             s2_valid_q, s2_valid_d;
  logic [DW-1:0]    s2_data_q,  s2_data_d;
  logic [LW-1:0]    s2_lane_q,  s2_lane_d;
  logic             s2_miss_q,  s2_miss_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_load, s2_load, hit;
  logic [DW-1:0]    masked;

  lane_steer_prio_enc #(
    .LANES (LANES),
    .NSEL  (NSEL),
    .SEL_W (SEL_W),
    .LW    (LW)
  ) u_enc (
    .sel_i  (in_sel),
    .lane_o (enc_lane),
    .miss_o (enc_miss)
  );

  assign s2_load  = ~s2_valid_q | out_ready;
  assign s1_load  = ~s1_valid_q | s2_load;
  assign in_ready = s1_load;

  always_comb begin
    masked = '0;
`ifdef LANE_STEER_ALIGN_EN
    if (!s1_miss_q) masked[LANE_W-1:0] = s1_data_q[s1_lane_q*LANE_W +: LANE_W];
`else
    for (int l = 0; l < LANES; l++) begin
      if (!s1_miss_q && s1_lane_q == LW'(l)) masked[l*LANE_W +: LANE_W] = s1_data_q[l*LANE_W +: LANE_W];
    end
`endif
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_lane_d  = s1_lane_q;
    s1_miss_d  = s1_miss_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_lane_d = enc_lane;
        s1_miss_d = enc_miss;
      end
    end
  end

  // Payload registers only move with a real word, so held outputs stay stable
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_lane_d  = s2_lane_q;
    s2_miss_d  = s2_miss_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = masked;
        s2_lane_d = s1_lane_q;
        s2_miss_d = s1_miss_q;
      end
    end
  end

  assign hit = s2_valid_q & out_ready & ~s2_miss_q;

  always_comb begin
    cnt_d = cnt_q;
    if (count_clr)                cnt_d = '0;
    else if (hit && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_lane_q  <= '0;
      s1_miss_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_lane_q  <= '0;
      s2_miss_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_lane_q  <= s1_lane_d;
      s1_miss_q  <= s1_miss_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_lane_q  <= s2_lane_d;
      s2_miss_q  <= s2_miss_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_lane  = s2_lane_q;
  assign out_miss  = s2_miss_q;
  assign hit_count = cnt_q;

endmodule
